// File: rtl/stim_driver.sv
// Stimulus driver: issues operand pairs (LFSR, walking-one, corner table,
// constant) to a DUT and tallies mismatch events reported by a checker.
module stim_driver #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned EVT_LAT = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [1:0]         i_mode,
  input  logic [WIDTH-1:0]   i_seed,
  input  logic [WIDTH-1:0]   i_seed_b,
  input  logic [31:0]        i_num_tests,
  input  logic               i_stop_on_event,
  input  logic               i_event,
  output logic [WIDTH-1:0]   o_dut_ia,
  output logic [WIDTH-1:0]   o_dut_ib,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [31:0]        o_test_cnt,
  output logic [15:0]        o_err_cnt,
  output logic               o_fail_seen,
  output logic [31:0]        o_first_fail_idx
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned ERR_W = 16;
  localparam int unsigned DRN_W = (EVT_LAT > 1) ? $clog2(EVT_LAT) : 1;
  localparam logic [WIDTH-1:0] LFSR_POLY = WIDTH'(32'h80200003);
  localparam logic [WIDTH-1:0] SEED_B_XOR = WIDTH'(32'hA5A5A5A5);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_mode, w_mode_nxt;
  logic [CNT_W-1:0]   r_num_tests, w_num_tests_nxt;
  logic [DRN_W-1:0]   r_drain_cnt, w_drain_cnt_nxt;
  logic [WIDTH-1:0]   r_dut_ia, w_dut_ia_nxt;
  logic [WIDTH-1:0]   r_dut_ib, w_dut_ib_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [CNT_W-1:0]   r_test_cnt, w_test_cnt_nxt;
  logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nxt;
  logic               r_fail_seen, w_fail_seen_nxt;
  logic [CNT_W-1:0]   r_first_fail_idx, w_first_fail_idx_nxt;
  logic [CNT_W-1:0]   w_fail_base;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] s);
    nonzero = (s == '0) ? WIDTH'(1) : s;
  endfunction

  function automatic logic [WIDTH-1:0] corner(input logic [2:0] idx);
    case (idx)
      3'd0:    corner = WIDTH'(32'h00000000);
      3'd1:    corner = WIDTH'(32'h00000001);
      3'd2:    corner = WIDTH'(32'h7FFFFFFF);
      3'd3:    corner = WIDTH'(32'h80000000);
      3'd4:    corner = WIDTH'(32'hFFFFFFFF);
      3'd5:    corner = WIDTH'(32'h00800000);
      3'd6:    corner = WIDTH'(32'h7F800000);
      default: corner = WIDTH'(32'h3F800000);
    endcase
  endfunction

  // State and all output registers; reset clears everything and aborts any run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_mode           <= '0;
      r_num_tests      <= '0;
      r_drain_cnt      <= '0;
      r_dut_ia         <= '0;
      r_dut_ib         <= '0;
      r_valid          <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_test_cnt       <= '0;
      r_err_cnt        <= '0;
      r_fail_seen      <= 1'b0;
      r_first_fail_idx <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_mode           <= w_mode_nxt;
      r_num_tests      <= w_num_tests_nxt;
      r_drain_cnt      <= w_drain_cnt_nxt;
      r_dut_ia         <= w_dut_ia_nxt;
      r_dut_ib         <= w_dut_ib_nxt;
      r_valid          <= w_valid_nxt;
      r_busy           <= w_busy_nxt;
      r_done           <= w_done_nxt;
      r_test_cnt       <= w_test_cnt_nxt;
      r_err_cnt        <= w_err_cnt_nxt;
      r_fail_seen      <= w_fail_seen_nxt;
      r_first_fail_idx <= w_first_fail_idx_nxt;
    end
  end

  // Next-state, pair generation and event bookkeeping.
  always_comb begin
    w_state_nxt          = r_state;
    w_mode_nxt           = r_mode;
    w_num_tests_nxt      = r_num_tests;
    w_drain_cnt_nxt      = r_drain_cnt;
    w_dut_ia_nxt         = r_dut_ia;
    w_dut_ib_nxt         = r_dut_ib;
    w_valid_nxt          = r_valid;
    w_busy_nxt           = r_busy;
    w_done_nxt           = r_done;
    w_test_cnt_nxt       = r_test_cnt;
    w_err_cnt_nxt        = r_err_cnt;
    w_fail_seen_nxt      = r_fail_seen;
    w_first_fail_idx_nxt = r_first_fail_idx;
    w_fail_base = (r_test_cnt >= CNT_W'(EVT_LAT)) ? (r_test_cnt - CNT_W'(EVT_LAT)) : '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start && !i_stop) begin
          w_state_nxt          = S_RUN;
          w_mode_nxt           = i_mode;
          w_num_tests_nxt      = i_num_tests;
          w_valid_nxt          = 1'b1;
          w_busy_nxt           = 1'b1;
          w_done_nxt           = 1'b0;
          w_test_cnt_nxt       = CNT_W'(1);
          w_err_cnt_nxt        = '0;
          w_fail_seen_nxt      = 1'b0;
          w_first_fail_idx_nxt = '0;
          // Pair 0 is launched on the start edge so it shows in the first RUN cycle.
          case (i_mode)
            2'b00: begin
              w_dut_ia_nxt = nonzero(i_seed);
              w_dut_ib_nxt = nonzero(i_seed ^ SEED_B_XOR);
            end
            2'b01: begin
              w_dut_ia_nxt = WIDTH'(1);
              w_dut_ib_nxt = ~WIDTH'(1);
            end
            2'b10: begin
              w_dut_ia_nxt = corner(3'd0);
              w_dut_ib_nxt = corner(3'd0);
            end
            default: begin
              w_dut_ia_nxt = i_seed;
              w_dut_ib_nxt = i_seed_b;
            end
          endcase
        end
      end
      S_RUN: begin
        if (((r_num_tests != '0) && (r_test_cnt == r_num_tests)) || i_stop ||
            (i_event && i_stop_on_event)) begin
          w_state_nxt     = S_DRAIN;
          w_valid_nxt     = 1'b0;
          w_drain_cnt_nxt = '0;
        end else begin
          // r_test_cnt equals the 0-based index of the pair being generated.
          w_test_cnt_nxt = r_test_cnt + CNT_W'(1);
          case (r_mode)
            2'b00: begin
              w_dut_ia_nxt = lfsr_step(r_dut_ia);
              w_dut_ib_nxt = lfsr_step(r_dut_ib);
            end
            2'b01: begin
              w_dut_ia_nxt = WIDTH'(1) << r_test_cnt[4:0];
              w_dut_ib_nxt = ~(WIDTH'(1) << r_test_cnt[4:0]);
            end
            2'b10: begin
              w_dut_ia_nxt = corner(r_test_cnt[5:3]);
              w_dut_ib_nxt = corner(r_test_cnt[2:0]);
            end
            default: begin
              w_dut_ia_nxt = r_dut_ia;
              w_dut_ib_nxt = r_dut_ib;
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (i_stop || (r_drain_cnt == DRN_W'(EVT_LAT - 1))) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DRN_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Events only matter while pairs may still be in flight through the checker.
    if (((r_state == S_RUN) || (r_state == S_DRAIN)) && i_event) begin
      if (r_err_cnt != ERR_MAX) w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
      if (!r_fail_seen) begin
        w_fail_seen_nxt      = 1'b1;
        w_first_fail_idx_nxt = w_fail_base;
      end
    end
  end

  assign o_dut_ia         = r_dut_ia;
  assign o_dut_ib         = r_dut_ib;
  assign o_valid          = r_valid;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_test_cnt       = r_test_cnt;
  assign o_err_cnt        = r_err_cnt;
  assign o_fail_seen      = r_fail_seen;
  assign o_first_fail_idx = r_first_fail_idx;

endmodule

// File: doc/stim_driver.md
STIM_DRIVER -- requirements
Module: stim_driver

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH  32  operand width; only 32 supported
  EVT_LAT  6  cycles from a pair leaving o_dut_ia/ib to its mismatch appearing on i_event
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock
  reset_n  in  1  asynchronous, active-low reset
  i_start  in  1  single-cycle pulse; begins a run
  i_stop  in  1  single-cycle pulse; aborts the run
  i_mode  in  2  00 LFSR random, 01 walking-one, 10 corner table, 11 constant
  i_seed  in  32  LFSR seed (mode 00); constant a (mode 11)
  i_seed_b  in  32  constant b (mode 11)
  i_num_tests  in  32  pairs per run; 0 = unbounded
  i_stop_on_event  in  1  end the run at the first mismatch
  i_event  in  1  mismatch pulse from the checker
  o_dut_ia  out  32  operand a
  o_dut_ib  out  32  operand b
  o_valid  out  1  pair on o_dut_ia/ib is a real test
  o_busy  out  1  high in RUN or DRAIN
  o_done  out  1  high in DONE
  o_test_cnt  out  32  pairs issued this run
  o_err_cnt  out  16  events counted; saturates at 16'hFFFF
  o_fail_seen  out  1  at least one event this run
  o_first_fail_idx  out  32  index of the first failing pair
REQ-003 Clock and reset SHALL be one clock, clk; reset_n asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-005 IDLE/DONE + i_start (i_stop low) -> RUN next cycle; counters, o_fail_seen, o_first_fail_idx and mode sequence reset on that edge.
REQ-006 i_start SHALL be ignored in RUN and DRAIN; if i_start and i_stop arrive together in IDLE/DONE, i_stop wins and the state is unchanged.
REQ-007 In RUN, o_valid SHALL be 1 and a new pair SHALL appear every cycle, with o_test_cnt incremented per pair; the first pair appears in the first RUN cycle.
REQ-008 RUN -> DRAIN on the cycle after the pair with o_test_cnt == i_num_tests (i_num_tests != 0), so exactly i_num_tests o_valid cycles occur.
REQ-009 RUN -> DRAIN on the cycle after i_stop, or after i_event when i_stop_on_event=1.
REQ-010 In DRAIN, o_valid=0 and o_dut_ia/ib SHALL hold the last pair; after EVT_LAT cycles -> DONE.
REQ-011 DONE SHALL hold o_done=1 and all counters stable until the next i_start; i_stop in DRAIN -> DONE immediately.
REQ-012 i_event SHALL be counted only in RUN/DRAIN; it SHALL be ignored in IDLE/DONE.
REQ-013 On the first counted event, o_fail_seen=1 and o_first_fail_idx = o_test_cnt - EVT_LAT, floored at 0 (0-based pair index).
REQ-014 Mode 00: two 32-bit Galois LFSRs, polynomial 32'h80200003, shifting once per pair.
  - a seed = i_seed; b seed = i_seed ^ 32'hA5A5A5A5.
  - Any zero seed SHALL be replaced by 32'h1.
  - The first pair SHALL be the seeds.
REQ-015 Mode 01: pair k SHALL be a = 1 << (k mod 32), b = ~a.
REQ-016 Mode 10: table T = {0, 1, 7FFFFFFF, 80000000, FFFFFFFF, 00800000, 7F800000, 3F800000}; pair k SHALL be a = T[k[5:3]], b = T[k[2:0]], wrapping after 64.
REQ-017 Mode 11: a = i_seed and b = i_seed_b, sampled at start.
REQ-018 i_mode, i_seed and i_num_tests SHALL be sampled at i_start; changes during a run SHALL be ignored.
REQ-019 o_test_cnt SHALL wrap modulo 2^32 in unbounded runs.

Reset
REQ-020 reset_n low SHALL asynchronously force IDLE and set all outputs to 0, including o_dut_ia/ib, o_valid, o_busy, o_done and all counters.
REQ-021 reset_n low mid-run SHALL abort the run with no DRAIN; after reset_n deasserts, the block stays in IDLE until i_start.

Verification
REQ-022 Mode 00, i_seed=1, N=4 -> 4 o_valid cycles, pair0 = (1, A5A5A5A4), then EVT_LAT drain cycles, then o_done=1 with o_test_cnt=4.
REQ-023 Mode 10, N=70 -> pairs 0..63 cover all T×T combinations, pair 64 = (0,0), o_err_cnt=0.
REQ-024 Mode 01, N=0, i_event injected once when o_test_cnt=20 with i_stop_on_event=1 -> DRAIN next cycle, o_first_fail_idx=14, o_err_cnt=1.
REQ-025 i_start and i_stop in the same cycle from IDLE -> stays IDLE; i_start during RUN -> no effect on counters.
REQ-026 reset_n low while o_test_cnt=10 in RUN -> outputs 0 immediately (asynchronous); a fresh i_start reissues pair0.
REQ-027 An i_event pulse every RUN cycle for 70000 cycles -> o_err_cnt saturates at FFFF.
